// File: rtl/pipelined_lookahead_adder.sv
// pipelined_lookahead_adder: N-bit two-level carry-lookahead adder/subtractor cut into STAGES slices.
// Define LA_ADDER_OVF_EN to add the signed-overflow output ovf.
module pipelined_lookahead_adder #(
    parameter int N      = 16,
    parameter int STAGES = 2,
    parameter int G      = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         ci,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sumAB,
`ifdef LA_ADDER_OVF_EN
    output logic         ovf,
`endif
    output logic         cAB
);
    localparam int W  = N / STAGES;
    localparam int NG = W / G;

    if (STAGES < 1 || N % (STAGES * G) != 0) begin : g_bad_cfg
        $error("pipelined_lookahead_adder: N must be a multiple of STAGES*G");
    end

    // Returns {carry_out, sum}; every carry is a flat sum of products of p/g terms.
    function automatic logic [W:0] cla(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [W-1:0] p, g, c;
        logic [NG-1:0] gp, gg;
        logic [NG:0] gc;
        logic t;
        p = a ^ b;
        g = a & b;
        for (int i = 0; i < NG; i++) begin
            gp[i] = &p[i*G +: G];
            gg[i] = 1'b0;
            for (int j = 0; j < G; j++) begin
                t = g[i*G+j];
                for (int m = j + 1; m < G; m++) t = t & p[i*G+m];
                gg[i] = gg[i] | t;
            end
        end
        for (int i = 0; i <= NG; i++) begin
            t = cin;
            for (int m = 0; m < i; m++) t = t & gp[m];
            gc[i] = t;
            for (int j = 0; j < i; j++) begin
                t = gg[j];
                for (int m = j + 1; m < i; m++) t = t & gp[m];
                gc[i] = gc[i] | t;
            end
        end
        for (int i = 0; i < NG; i++) begin
            for (int j = 0; j < G; j++) begin
                t = gc[i];
                for (int m = 0; m < j; m++) t = t & p[i*G+m];
                c[i*G+j] = t;
                for (int l = 0; l < j; l++) begin
                    t = g[i*G+l];
                    for (int m = l + 1; m < j; m++) t = t & p[i*G+m];
                    c[i*G+j] = c[i*G+j] | t;
                end
            end
        end
        return {gc[NG], p ^ c};
    endfunction

    logic [N-1:0] a_q [STAGES], b_q [STAGES], s_q [STAGES];
    logic [N-1:0] a_i [STAGES], b_i [STAGES], s_i [STAGES];
    logic         c_q [STAGES], v_q [STAGES], c_i [STAGES], v_i [STAGES];
    logic [W:0]   r   [STAGES];
    logic         advance;

    assign advance  = !v_q[STAGES-1] || out_ready;
    assign in_ready = advance;

    // Stage k adds slice k; operands above it ride along, finished slices below it are carried forward.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign a_i[k] = A;
            assign b_i[k] = sub ? ~B : B;
            assign c_i[k] = sub | ci;
            assign v_i[k] = in_valid;
            assign s_i[k] = '0;
        end else begin : g_body
            assign a_i[k] = a_q[k-1];
            assign b_i[k] = b_q[k-1];
            assign c_i[k] = c_q[k-1];
            assign v_i[k] = v_q[k-1];
            assign s_i[k] = s_q[k-1];
        end
        assign r[k] = cla(a_i[k][k*W +: W], b_i[k][k*W +: W], c_i[k]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]           <= a_i[k];
                b_q[k]           <= b_i[k];
                s_q[k]           <= s_i[k];
                s_q[k][k*W +: W] <= r[k][W-1:0];
                c_q[k]           <= r[k][W];
                v_q[k]           <= v_i[k];
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign sumAB     = s_q[STAGES-1];
    assign cAB       = c_q[STAGES-1];
`ifdef LA_ADDER_OVF_EN
    // Carry into the MSB is recovered as sum ^ a ^ b of that bit.
    assign ovf = s_q[STAGES-1][N-1] ^ a_q[STAGES-1][N-1] ^ b_q[STAGES-1][N-1] ^ c_q[STAGES-1];
`endif
endmodule

// File: tb/tb_pipelined_lookahead_adder.sv
// tb_pipelined_lookahead_adder: directed checks on STAGES=2 plus random streams on STAGES=1 and STAGES=4.
module tb_pipelined_lookahead_adder;
    logic        clk = 1'b0, rst = 1'b1, iv = 1'b0, rv = 1'b0, ordy = 1'b1, ci = 1'b0, sub = 1'b0;
    logic [15:0] A = '0, B = '0;
    logic        ir2, ov2, c2, ir1, ov1, c1, ir4, ov4, c4;
    logic [15:0] s2, s1, s4;
`ifdef LA_ADDER_OVF_EN
    logic        o2, o1, o4;
`endif
    int          n_chk = 0, n_err = 0;
    logic [17:0] hist [64];

    always #5 clk = ~clk;

    pipelined_lookahead_adder #(.N(16), .STAGES(2), .G(4)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir2), .A(A), .B(B), .ci(ci), .sub(sub),
        .out_valid(ov2), .out_ready(ordy), .sumAB(s2),
`ifdef LA_ADDER_OVF_EN
        .ovf(o2),
`endif
        .cAB(c2));
    pipelined_lookahead_adder #(.N(16), .STAGES(1), .G(4)) u1 (
        .clk(clk), .rst(rst), .in_valid(rv), .in_ready(ir1), .A(A), .B(B), .ci(ci), .sub(sub),
        .out_valid(ov1), .out_ready(1'b1), .sumAB(s1),
`ifdef LA_ADDER_OVF_EN
        .ovf(o1),
`endif
        .cAB(c1));
    pipelined_lookahead_adder #(.N(16), .STAGES(4), .G(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(rv), .in_ready(ir4), .A(A), .B(B), .ci(ci), .sub(sub),
        .out_valid(ov4), .out_ready(1'b1), .sumAB(s4),
`ifdef LA_ADDER_OVF_EN
        .ovf(o4),
`endif
        .cAB(c4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
        iv = v; A = a; B = b; ci = c; sub = s;
    endtask

    task automatic chk_out(input string tag, input logic [15:0] s, input logic c);
        chk({tag, ".valid"}, 32'(ov2), 32'd1);
        chk({tag, ".sum"}, 32'(s2), 32'(s));
        chk({tag, ".cout"}, 32'(c2), 32'(c));
    endtask

    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
        logic [15:0] bx;
        logic [16:0] r;
        bx = s ? ~b : b;
        r  = {1'b0, a} + {1'b0, bx} + 17'(s | c);
        return {(a[15] == bx[15]) && (r[15] != a[15]), r};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick;
        chk("rst.valid", 32'(ov2), 32'd0);
        chk("rst.sum", 32'(s2), 32'd0);
        chk("rst.cout", 32'(c2), 32'd0);
        chk("rst.in_ready", 32'(ir2), 32'd1);
        tick;
        rst = 1'b0;

        drive(1, 16'h1234, 16'h4321, 0, 0);
        tick;
        chk("t1.latency", 32'(ov2), 32'd0);
        drive(1, 16'hFFFF, 16'h0000, 1, 0);
        tick;
        chk_out("t1", 16'h5555, 1'b0);
        drive(1, 16'h0005, 16'h0003, 0, 1);
        tick;
        chk_out("t2", 16'h0000, 1'b1);
        drive(1, 16'h0003, 16'h0005, 0, 1);
        tick;
        chk_out("t3a", 16'h0002, 1'b1);
        iv = 1'b0;
        tick;
        chk_out("t3b", 16'hFFFE, 1'b0);
        tick;
        chk("t3.bubble", 32'(ov2), 32'd0);

        drive(1, 16'h0001, 16'h0002, 0, 0);
        tick;
        drive(1, 16'h0010, 16'h0020, 0, 0);
        tick;
        chk_out("t4.first", 16'h0003, 1'b0);
        ordy = 1'b0;
        drive(1, 16'h0100, 16'h0200, 0, 0);
        #1;
        chk("t4.in_ready_low", 32'(ir2), 32'd0);
        repeat (3) begin
            tick;
            chk_out("t4.hold", 16'h0003, 1'b0);
            chk("t4.hold_ready", 32'(ir2), 32'd0);
        end
        ordy = 1'b1;
        iv = 1'b0;
        #1;
        chk("t4.in_ready_high", 32'(ir2), 32'd1);
        tick;
        chk_out("t4.second", 16'h0030, 1'b0);
        tick;
        chk("t4.drained", 32'(ov2), 32'd0);
        tick;
        chk("t4.no_extra", 32'(ov2), 32'd0);

        drive(1, 16'h1111, 16'h1111, 0, 0);
        tick;
        drive(1, 16'h2222, 16'h2222, 0, 0);
        tick;
        chk_out("t5.pre", 16'h2222, 1'b0);
        iv = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("t5.rst_valid", 32'(ov2), 32'd0);
        chk("t5.rst_sum", 32'(s2), 32'd0);
        chk("t5.rst_ready", 32'(ir2), 32'd1);
        tick;
        rst = 1'b0;
        repeat (3) begin
            tick;
            chk("t5.no_stale", 32'(ov2), 32'd0);
        end
        drive(1, 16'h0F0F, 16'h0101, 0, 0);
        tick;
        iv = 1'b0;
        chk("t5.latency", 32'(ov2), 32'd0);
        tick;
        chk_out("t5.after", 16'h1010, 1'b0);

`ifdef LA_ADDER_OVF_EN
        drive(1, 16'h7FFF, 16'h0001, 0, 0);
        tick;
        drive(1, 16'h8000, 16'h0001, 0, 1);
        tick;
        chk_out("t6a", 16'h8000, 1'b0);
        chk("t6a.ovf", 32'(o2), 32'd1);
        iv = 1'b0;
        tick;
        chk_out("t6b", 16'h7FFF, 1'b1);
        chk("t6b.ovf", 32'(o2), 32'd1);
`endif

        rv = 1'b1;
        for (int i = 0; i < 40; i++) begin
            drive(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            hist[i] = model(A, B, ci, sub);
            tick;
            chk("s1.valid", 32'(ov1), 32'd1);
            chk("s1.data", 32'({c1, s1}), 32'(hist[i][16:0]));
`ifdef LA_ADDER_OVF_EN
            chk("s1.ovf", 32'(o1), 32'(hist[i][17]));
`endif
            if (i < 3) begin
                chk("s4.fill", 32'(ov4), 32'd0);
            end else begin
                chk("s4.valid", 32'(ov4), 32'd1);
                chk("s4.data", 32'({c4, s4}), 32'(hist[i-3][16:0]));
`ifdef LA_ADDER_OVF_EN
                chk("s4.ovf", 32'(o4), 32'(hist[i-3][17]));
`endif
            end
        end
        rv = 1'b0;
        tick;
        chk("s1.drain", 32'(ov1), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
